alu_seq: RTL

Multi-cycle ALU sequencer: accepts one operation request, drives the single-cycle 8-bit ALU over one or more cycles, and returns an 8-bit result with a one-cycle response pulse. It sits between the decode/control logic and the ALU, owning the ALU's `alu_cmd`, `ALU_Op`, `inA` and `inB` inputs while busy. It provides single ops, N-fold repeated ops, and an iterative population count built only from existing ALU primitives.

---
 rtl/alu_seq_pkg.sv | 48 ++++
 rtl/alu_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq_pkg : operation/state types and ALU encodings for alu_seq
// Rev 1.0     : optional POPCNT states follow ALU_SEQ_POPCNT_EN
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [1:0] {
    SINGLE = 2'b00,
    REPEAT = 2'b01,
    POPCNT = 2'b10,
    RSVD   = 2'b11
  } seq_op_t;

`ifdef ALU_SEQ_POPCNT_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    PC_TEST  = 3'd2,
    PC_INC   = 3'd3,
    PC_SHIFT = 3'd4,
    DONE     = 3'd5
  } seq_state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    DONE = 3'd5
  } seq_state_t;
`endif

  localparam logic [1:0] ALUOP_LOGIC = 2'b00;
  localparam logic [1:0] ALUOP_DEC   = 2'b01;
  localparam logic [1:0] ALUOP_INC   = 2'b10;
  localparam logic [1:0] ALUOP_SUB   = 2'b11;
  localparam logic [2:0] CMD_SHR     = 3'b010;
  localparam logic [2:0] CMD_AND     = 3'b011;

  function automatic logic op_is_error(input seq_op_t op);
`ifdef ALU_SEQ_POPCNT_EN
    return (op == RSVD);
`else
    return (op == RSVD) || (op == POPCNT);
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq : multi-cycle sequencer driving an external single-cycle 8-bit ALU
// Rev 1.0 : POPCNT support compiled in with ALU_SEQ_POPCNT_EN
// ---------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [2:0]       req_cmd,
  input  logic [1:0]       req_aluop,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  input  logic [CNT_W-1:0] req_cnt,
  output logic [2:0]       alu_cmd_o,
  output logic [1:0]       alu_op_o,
  output logic [7:0]       alu_a_o,
  output logic [7:0]       alu_b_o,
  input  logic [7:0]       alu_rslt_i,
  output logic             resp_valid,
  output logic [7:0]       resp_data,
  output logic             resp_err
);

  seq_state_t       state;
  logic [7:0]       acc;
  logic [7:0]       opb;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       cmd;
  logic [1:0]       aluop;
`ifdef ALU_SEQ_POPCNT_EN
  logic [7:0]       pc;
`endif

  assign req_ready = (state == IDLE);

  // ALU drive is decoded from the registered state so the result returns
  // within the same cycle and is captured on the edge that ends it.
  always_comb begin
    alu_cmd_o = 3'b000;
    alu_op_o  = 2'b00;
    alu_a_o   = 8'h00;
    alu_b_o   = 8'h00;
    case (state)
      RUN: begin
        alu_cmd_o = cmd;
        alu_op_o  = aluop;
        alu_a_o   = acc;
        alu_b_o   = opb;
      end
`ifdef ALU_SEQ_POPCNT_EN
      PC_TEST: begin
        alu_cmd_o = CMD_AND;
        alu_op_o  = ALUOP_LOGIC;
        alu_a_o   = acc;
        alu_b_o   = 8'h01;
      end
      PC_INC: begin
        alu_op_o  = ALUOP_INC;
        alu_a_o   = pc;
      end
      PC_SHIFT: begin
        alu_cmd_o = CMD_SHR;
        alu_op_o  = ALUOP_LOGIC;
        alu_a_o   = acc;
        alu_b_o   = 8'h01;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= 8'h00;
      opb        <= 8'h00;
      cnt        <= '0;
      cmd        <= 3'b000;
      aluop      <= 2'b00;
`ifdef ALU_SEQ_POPCNT_EN
      pc         <= 8'h00;
`endif
      resp_valid <= 1'b0;
      resp_data  <= 8'h00;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            acc      <= req_a;
            opb      <= req_b;
            cmd      <= req_cmd;
            aluop    <= req_aluop;
            resp_err <= 1'b0;
            if (op_is_error(seq_op_t'(req_op))) begin
              resp_err   <= 1'b1;
              resp_data  <= 8'h00;
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              case (seq_op_t'(req_op))
                SINGLE: begin
                  cnt   <= CNT_W'(1);
                  state <= RUN;
                end
                REPEAT: begin
                  cnt <= req_cnt;
                  if (req_cnt == '0) begin
                    resp_data  <= req_a;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                  end else begin
                    state <= RUN;
                  end
                end
`ifdef ALU_SEQ_POPCNT_EN
                POPCNT: begin
                  pc <= 8'h00;
                  if (req_a == 8'h00) begin
                    resp_data  <= 8'h00;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                  end else begin
                    state <= PC_TEST;
                  end
                end
`endif
                default: state <= IDLE;
              endcase
            end
          end
        end
        RUN: begin
          acc <= alu_rslt_i;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            resp_data  <= alu_rslt_i;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
`ifdef ALU_SEQ_POPCNT_EN
        PC_TEST: state <= alu_rslt_i[0] ? PC_INC : PC_SHIFT;
        PC_INC: begin
          pc    <= alu_rslt_i;
          state <= PC_SHIFT;
        end
        PC_SHIFT: begin
          acc <= alu_rslt_i;
          if (alu_rslt_i == 8'h00) begin
            resp_data  <= pc;
            resp_valid <= 1'b1;
            state      <= DONE;
          end else begin
            state <= PC_TEST;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
